// File: rtl/inv_substitution_layer_serial_if.sv
// Ascon state types plus the handshake bundle between the inverse S-box layer and its producer/consumer.
package ascon_pkg;
  localparam int WORD_WIDTH = 64;
  typedef logic [WORD_WIDTH-1:0] ascon_word_t;
  // Element 0 is x0, the word that supplies the MSB of each column index.
  typedef ascon_word_t [4:0] ascon_state_t;

  localparam logic [4:0] INV_SBOX [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  function automatic logic [4:0] inv_sbox(input logic [4:0] x);
    return INV_SBOX[x];
  endfunction
endpackage

interface inv_substitution_layer_serial_if;
  import ascon_pkg::*;

  logic         in_valid_i;
  logic         in_ready_o;
  ascon_state_t state_i;
  logic         out_valid_o;
  logic         out_ready_i;
  ascon_state_t state_o;
  logic         busy_o;

  modport slave (
    input  in_valid_i, state_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o, busy_o
  );

  modport master (
    output in_valid_i, state_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o, busy_o
  );
endinterface

// File: rtl/inv_substitution_layer_serial.sv
// Serial inverse Ascon S-box layer: inverts LANES bit-columns per cycle of a captured 320-bit state.
module inv_substitution_layer_serial
  import ascon_pkg::*;
#(
  parameter int LANES = 8
) (
  input logic clk_i,
  input logic rst_i,
  inv_substitution_layer_serial_if.slave bus
);

  localparam int NSLICE = WORD_WIDTH / LANES;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       state_q, state_d;
  logic [CW-1:0] cnt_q;
  ascon_state_t work_q;
  logic         last_slice;

  logic [LANES-1:0] slice_in  [5];
  logic [LANES-1:0] slice_new [5];

  assign last_slice = (cnt_q == CW'(NSLICE - 1));

  always_comb begin
    for (int k = 0; k < 5; k++) slice_in[k] = work_q[k][int'(cnt_q) * LANES +: LANES];
  end

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < 5; k++) slice_new[k] = '0;
    for (int l = 0; l < LANES; l++) begin
      {slice_new[0][l], slice_new[1][l], slice_new[2][l], slice_new[3][l], slice_new[4][l]} =
        inv_sbox({slice_in[0][l], slice_in[1][l], slice_in[2][l], slice_in[3][l], slice_in[4][l]});
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid_i)  state_d = BUSY;
      BUSY:    if (last_slice)      state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.busy_o      = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready_o  = 1'b1;
      BUSY:    bus.busy_o      = 1'b1;
      DONE:    bus.out_valid_o = 1'b1;
      default: bus.in_ready_o  = 1'b0;
    endcase
  end

  // NOTE: the working register is reset too, so state_o reads zero after reset instead of stale data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid_i) begin
          work_q <= bus.state_i;
          cnt_q  <= '0;
        end
        BUSY: begin
          // Columns are rewritten in place; the counter wraps to 0 as the last slice completes.
          for (int k = 0; k < 5; k++) work_q[k][int'(cnt_q) * LANES +: LANES] <= slice_new[k];
          cnt_q <= last_slice ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state_o = work_q;

endmodule
